// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the set-associative icache.
package icache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   localparam int OFFSET_LSB = 2;

   function automatic int tag_w(int aw, int sw, int bw);
      return aw - sw - bw - OFFSET_LSB;
   endfunction

   function automatic logic [63:0] addr_field(logic [63:0] a, int lsb, int w);
      logic [63:0] m;
      m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (a >> lsb) & m;
   endfunction

   function automatic logic [63:0] get_offset(logic [63:0] a, int bw);
      return addr_field(a, OFFSET_LSB, bw);
   endfunction

   function automatic logic [63:0] get_index(logic [63:0] a, int bw, int sw);
      return addr_field(a, OFFSET_LSB + bw, sw);
   endfunction

   function automatic logic [63:0] get_tag(logic [63:0] a, int bw, int sw);
      return a >> (OFFSET_LSB + bw + sw);
   endfunction

   function automatic logic [63:0] block_base(logic [63:0] a, int bw);
      return a & ~((64'd1 << (OFFSET_LSB + bw)) - 64'd1);
   endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays, combinational read, block refill write.
module icache_way
   import icache_pkg::*;
#(
   parameter int SET_WIDTH   = 6,
   parameter int BLOCK_WIDTH = 2,
   parameter int TAG_WIDTH   = 22,
   parameter int OFF_W       = 2
) (
   input  logic                             Sys_clk,
   input  logic                             Sys_rst,
   input  logic [SET_WIDTH-1:0]             rd_index,
   input  logic [TAG_WIDTH-1:0]             rd_tag,
   input  logic [OFF_W-1:0]                 rd_offset,
   output logic                             hit,
   output logic                             set_valid,
   output logic [31:0]                      word,
   input  logic                             wr_en,
   input  logic [SET_WIDTH-1:0]             wr_index,
   input  logic [TAG_WIDTH-1:0]             wr_tag,
   input  logic [32*(1<<BLOCK_WIDTH)-1:0]   wr_block,
   input  logic                             inv_all
);

   localparam int SETS = 1 << SET_WIDTH;
   localparam int BW   = 32 * (1 << BLOCK_WIDTH);

   logic [SETS-1:0]      valid;
   logic [TAG_WIDTH-1:0] tags [SETS];
   logic [BW-1:0]        data [SETS];

   // A refill landing with a flush keeps its own line valid.
   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         valid <= '0;
      end else begin
         if (inv_all) valid <= '0;
         if (wr_en) valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge Sys_clk) begin
      if (wr_en) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_block;
      end
   end

   assign set_valid = valid[rd_index];
   assign hit       = valid[rd_index] && (tags[rd_index] == rd_tag);
   assign word      = data[rd_index][32*rd_offset +: 32];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache between IF and MC with
// round-robin replacement, fetch cancel and full invalidate.
module icache_sa
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 2,
   parameter int SET_WIDTH   = 6,
   parameter int WAY_WIDTH   = 1
) (
   input  logic                            Sys_clk,
   input  logic                            Sys_rst,
   input  logic                            Sys_rdy,
   input  logic                            IFIC_en,
   input  logic [ADDR_WIDTH-1:0]           IFIC_addr,
   output logic                            ICIF_en,
   output logic [31:0]                     ICIF_data,
   output logic                            ICMC_en,
   output logic [ADDR_WIDTH-1:0]           ICMC_addr,
   input  logic                            MCIC_en,
   input  logic [32*(1<<BLOCK_WIDTH)-1:0]  MCIC_block,
   input  logic                            Clear_en,
   input  logic                            Inv_all
);

   localparam int NUM_WAYS  = 1 << WAY_WIDTH;
   localparam int NUM_SETS  = 1 << SET_WIDTH;
   localparam int TAG_WIDTH = tag_w(ADDR_WIDTH, SET_WIDTH, BLOCK_WIDTH);
   localparam int OFF_W     = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : 1;
   localparam int RR_W      = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

   logic [63:0]           a64;
   logic [OFF_W-1:0]      f_off;
   logic [SET_WIDTH-1:0]  f_idx;
   logic [TAG_WIDTH-1:0]  f_tag;

   assign a64   = 64'(IFIC_addr);
   assign f_off = OFF_W'(get_offset(a64, BLOCK_WIDTH));
   assign f_idx = SET_WIDTH'(get_index(a64, BLOCK_WIDTH, SET_WIDTH));
   assign f_tag = TAG_WIDTH'(get_tag(a64, BLOCK_WIDTH, SET_WIDTH));

   state_t                state_q, state_d;
   logic                  drop_q, drop_d;
   logic [OFF_W-1:0]      lat_off, lat_off_d;
   logic [SET_WIDTH-1:0]  lat_idx, lat_idx_d;
   logic [TAG_WIDTH-1:0]  lat_tag, lat_tag_d;
   logic [RR_W-1:0]       lat_way, lat_way_d;
   logic                  icif_en_q, icif_en_d;
   logic [31:0]           icif_data_q, icif_data_d;
   logic                  icmc_en_q, icmc_en_d;
   logic [ADDR_WIDTH-1:0] icmc_addr_q, icmc_addr_d;
   logic [RR_W-1:0]       rr_q [NUM_SETS];

   logic [NUM_WAYS-1:0]   way_hit;
   logic [NUM_WAYS-1:0]   way_valid;
   logic [NUM_WAYS-1:0]   way_we;
   logic [31:0]           way_word [NUM_WAYS];

   logic                  hit_any;
   logic [31:0]           hit_word;
   logic                  any_inv;
   logic [RR_W-1:0]       victim;
   logic                  refill;
   logic                  rr_inc;

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      assign way_we[w] = Sys_rdy && refill && (lat_way == RR_W'(w));

      icache_way #(
         .SET_WIDTH   (SET_WIDTH),
         .BLOCK_WIDTH (BLOCK_WIDTH),
         .TAG_WIDTH   (TAG_WIDTH),
         .OFF_W       (OFF_W)
      ) u_way (
         .Sys_clk   (Sys_clk),
         .Sys_rst   (Sys_rst),
         .rd_index  (f_idx),
         .rd_tag    (f_tag),
         .rd_offset (f_off),
         .hit       (way_hit[w]),
         .set_valid (way_valid[w]),
         .word      (way_word[w]),
         .wr_en     (way_we[w]),
         .wr_index  (lat_idx),
         .wr_tag    (lat_tag),
         .wr_block  (MCIC_block),
         .inv_all   (Sys_rdy && Inv_all)
      );
   end

   // At most one way matches, so an OR of gated words is a clean mux.
   always_comb begin
      hit_any  = |way_hit;
      hit_word = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (way_hit[w]) hit_word = hit_word | way_word[w];
      end
   end

   always_comb begin
      any_inv = 1'b0;
      victim  = rr_q[f_idx];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!way_valid[w]) begin
            any_inv = 1'b1;
            victim  = RR_W'(w);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      lat_off_d   = lat_off;
      lat_idx_d   = lat_idx;
      lat_tag_d   = lat_tag;
      lat_way_d   = lat_way;
      icif_en_d   = 1'b0;
      icif_data_d = icif_data_q;
      icmc_en_d   = icmc_en_q;
      icmc_addr_d = icmc_addr_q;
      refill      = 1'b0;
      rr_inc      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (IFIC_en && !Clear_en) begin
               if (hit_any) begin
                  icif_en_d   = 1'b1;
                  icif_data_d = hit_word;
               end else begin
                  state_d     = MISS;
                  lat_off_d   = f_off;
                  lat_idx_d   = f_idx;
                  lat_tag_d   = f_tag;
                  lat_way_d   = victim;
                  rr_inc      = !any_inv;
                  icmc_en_d   = 1'b1;
                  icmc_addr_d = ADDR_WIDTH'(block_base(a64, BLOCK_WIDTH));
               end
            end
         end
         MISS: begin
            if (Clear_en) drop_d = 1'b1;
            if (MCIC_en) begin
               refill    = 1'b1;
               state_d   = IDLE;
               icmc_en_d = 1'b0;
               drop_d    = 1'b0;
               if (!drop_q && !Clear_en) begin
                  icif_en_d   = 1'b1;
                  icif_data_d = MCIC_block[32*lat_off +: 32];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         state_q     <= IDLE;
         drop_q      <= 1'b0;
         lat_off     <= '0;
         lat_idx     <= '0;
         lat_tag     <= '0;
         lat_way     <= '0;
         icif_en_q   <= 1'b0;
         icif_data_q <= '0;
         icmc_en_q   <= 1'b0;
         icmc_addr_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      end else if (!Sys_rdy) begin
         icif_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drop_q      <= drop_d;
         lat_off     <= lat_off_d;
         lat_idx     <= lat_idx_d;
         lat_tag     <= lat_tag_d;
         lat_way     <= lat_way_d;
         icif_en_q   <= icif_en_d;
         icif_data_q <= icif_data_d;
         icmc_en_q   <= icmc_en_d;
         icmc_addr_q <= icmc_addr_d;
         if (rr_inc) begin
            rr_q[f_idx] <= (WAY_WIDTH == 0) ? '0 : rr_q[f_idx] + RR_W'(1);
         end
      end
   end

   assign ICIF_en   = icif_en_q;
   assign ICIF_data = icif_data_q;
   assign ICMC_en   = icmc_en_q;
   assign ICMC_addr = icmc_addr_q;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with a behavioural cache model and
// per-cycle output comparison.
module tb_icache_sa;

   localparam int AW = 32;
   localparam int BW = 1;
   localparam int SW = 2;
   localparam int WW = 1;

   logic        Sys_clk = 1'b0;
   logic        Sys_rst;
   logic        Sys_rdy;
   logic        IFIC_en;
   logic [31:0] IFIC_addr;
   logic        ICIF_en;
   logic [31:0] ICIF_data;
   logic        ICMC_en;
   logic [31:0] ICMC_addr;
   logic        MCIC_en;
   logic [63:0] MCIC_block;
   logic        Clear_en;
   logic        Inv_all;

   always #5 Sys_clk = ~Sys_clk;

   icache_sa #(
      .ADDR_WIDTH  (AW),
      .BLOCK_WIDTH (BW),
      .SET_WIDTH   (SW),
      .WAY_WIDTH   (WW)
   ) dut (
      .Sys_clk    (Sys_clk),
      .Sys_rst    (Sys_rst),
      .Sys_rdy    (Sys_rdy),
      .IFIC_en    (IFIC_en),
      .IFIC_addr  (IFIC_addr),
      .ICIF_en    (ICIF_en),
      .ICIF_data  (ICIF_data),
      .ICMC_en    (ICMC_en),
      .ICMC_addr  (ICMC_addr),
      .MCIC_en    (MCIC_en),
      .MCIC_block (MCIC_block),
      .Clear_en   (Clear_en),
      .Inv_all    (Inv_all)
   );

   int total = 0;
   int bad   = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   // Backing memory: two pinned words, the rest derived from the address.
   function automatic logic [31:0] mem_word(logic [31:0] a);
      if (a == 32'h100) return 32'hA;
      if (a == 32'h104) return 32'hB;
      return {16'hC0DE, a[15:0]};
   endfunction

   function automatic logic [63:0] mem_block(logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'h7;
      return {mem_word(b + 32'h4), mem_word(b)};
   endfunction

   // Model: per set, which block address each way holds.
   bit          mv [4][2];
   logic [31:0] mb [4][2];
   int          mrr [4];
   bit          pend;
   bit          mdrop;
   logic [31:0] paddr;
   int          pway;
   bit          e_icif;
   bit          e_icmc;
   logic [31:0] e_data;
   logic [31:0] e_mcaddr;
   bit          chk_on = 1'b0;

   function automatic int set_of(logic [31:0] a);
      return int'(a[4:3]);
   endfunction

   function automatic bit cached(logic [31:0] a);
      int s;
      s = set_of(a);
      for (int w = 0; w < 2; w++)
         if (mv[s][w] && mb[s][w] == (a & ~32'h7)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void clear_all();
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 2; w++) mv[s][w] = 1'b0;
   endfunction

   function automatic void model_reset();
      clear_all();
      for (int s = 0; s < 4; s++) mrr[s] = 0;
      pend = 0; mdrop = 0; e_icif = 0; e_icmc = 0;
      e_data = '0; e_mcaddr = '0;
   endfunction

   task automatic step();
      bit f, c, mc, iv, rd, rs;
      logic [31:0] a;
      int s, v;
      f = IFIC_en; a = IFIC_addr; c = Clear_en; mc = MCIC_en;
      iv = Inv_all; rd = Sys_rdy; rs = Sys_rst;
      @(posedge Sys_clk);
      #1;
      if (rs) begin
         model_reset();
      end else if (!rd) begin
         e_icif = 0;
      end else begin
         e_icif = 0;
         if (pend) begin
            if (mc) begin
               if (iv) clear_all();
               s = set_of(paddr);
               mv[s][pway] = 1'b1;
               mb[s][pway] = paddr & ~32'h7;
               pend = 0;
               e_icmc = 0;
               if (!mdrop && !c) begin
                  e_icif = 1;
                  e_data = mem_word(paddr);
               end
               mdrop = 0;
            end else begin
               if (c) mdrop = 1;
               if (iv) clear_all();
            end
         end else begin
            if (f && !c) begin
               if (cached(a)) begin
                  e_icif = 1;
                  e_data = mem_word(a);
               end else begin
                  s = set_of(a);
                  v = -1;
                  for (int w = 1; w >= 0; w--) if (!mv[s][w]) v = w;
                  if (v < 0) begin
                     v = mrr[s];
                     mrr[s] = (mrr[s] + 1) % 2;
                  end
                  pway = v; pend = 1; paddr = a;
                  e_icmc = 1;
                  e_mcaddr = a & ~32'h7;
               end
            end
            if (iv) clear_all();
         end
      end
   endtask

   always @(negedge Sys_clk) begin
      if (chk_on) begin
         check("cmp_icif_en", 32'(ICIF_en), 32'(e_icif));
         if (e_icif) check("cmp_icif_data", ICIF_data, e_data);
         check("cmp_icmc_en", 32'(ICMC_en), 32'(e_icmc));
         if (e_icmc) check("cmp_icmc_addr", ICMC_addr, e_mcaddr);
      end
   end

   task automatic fetch(logic [31:0] a, bit clr);
      IFIC_en = 1'b1; IFIC_addr = a; Clear_en = clr;
      step();
      IFIC_en = 1'b0; Clear_en = 1'b0;
   endtask

   task automatic refill(bit inv);
      MCIC_en = 1'b1; MCIC_block = mem_block(paddr); Inv_all = inv;
      step();
      MCIC_en = 1'b0; Inv_all = 1'b0;
   endtask

   task automatic fill(logic [31:0] a);
      fetch(a, 1'b0);
      refill(1'b0);
   endtask

   task automatic do_reset();
      Sys_rst = 1'b1;
      model_reset();
      step();
      step();
      Sys_rst = 1'b0;
   endtask

   initial begin
      Sys_rst = 1'b1; Sys_rdy = 1'b1; IFIC_en = 1'b0; IFIC_addr = '0;
      MCIC_en = 1'b0; MCIC_block = '0; Clear_en = 1'b0; Inv_all = 1'b0;
      model_reset();
      step();
      chk_on = 1'b1;
      do_reset();
      check("rst_icif_en", 32'(ICIF_en), 32'd0);
      check("rst_icif_data", ICIF_data, 32'd0);
      check("rst_icmc_en", 32'(ICMC_en), 32'd0);
      check("rst_icmc_addr", ICMC_addr, 32'd0);

      // Cold miss then hit on the other word of the block.
      fetch(32'h100, 1'b0);
      check("cold_icmc_en", 32'(ICMC_en), 32'd1);
      check("cold_icmc_addr", ICMC_addr, 32'h100);
      refill(1'b0);
      check("cold_icif_en", 32'(ICIF_en), 32'd1);
      check("cold_data", ICIF_data, 32'hA);
      fetch(32'h104, 1'b0);
      check("hit_icif_en", 32'(ICIF_en), 32'd1);
      check("hit_data", ICIF_data, 32'hB);
      check("hit_no_icmc", 32'(ICMC_en), 32'd0);
      MCIC_en = 1'b1; MCIC_block = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      MCIC_en = 1'b0;
      check("idle_mcic_ignored", 32'(ICIF_en), 32'd0);

      // Associativity and round-robin eviction in set 0.
      do_reset();
      fill(32'h000);
      fill(32'h020);
      fill(32'h040);
      fetch(32'h020, 1'b0);
      check("assoc_020_hit", 32'(ICIF_en), 32'd1);
      check("assoc_020_data", ICIF_data, 32'hC0DE0020);
      fetch(32'h000, 1'b0);
      check("assoc_000_miss", 32'(ICMC_en), 32'd1);
      refill(1'b0);

      // Cancel during a miss, and cancel in IDLE.
      do_reset();
      fetch(32'h200, 1'b0);
      step();
      Clear_en = 1'b1;
      step();
      Clear_en = 1'b0;
      step();
      refill(1'b0);
      check("cancel_no_icif", 32'(ICIF_en), 32'd0);
      check("cancel_icmc_low", 32'(ICMC_en), 32'd0);
      fetch(32'h200, 1'b0);
      check("cancel_refetch_hit", 32'(ICIF_en), 32'd1);
      check("cancel_refetch_data", ICIF_data, 32'hC0DE0200);
      fetch(32'h200, 1'b1);
      check("clear_idle_no_icif", 32'(ICIF_en), 32'd0);
      fetch(32'h300, 1'b1);
      check("clear_idle_no_icmc", 32'(ICMC_en), 32'd0);

      // Invalidate all.
      do_reset();
      for (int i = 0; i < 4; i++) fill(32'(i * 8));
      Inv_all = 1'b1;
      fetch(32'h008, 1'b0);
      Inv_all = 1'b0;
      check("inv_hit_returned", 32'(ICIF_en), 32'd1);
      for (int i = 0; i < 4; i++) begin
         fetch(32'(i * 8), 1'b0);
         check("inv_all_miss", 32'(ICMC_en), 32'd1);
         refill(1'b0);
      end
      fetch(32'h020, 1'b0);
      refill(1'b1);
      fetch(32'h020, 1'b0);
      check("inv_refill_kept", 32'(ICIF_en), 32'd1);
      fetch(32'h008, 1'b0);
      check("inv_refill_others", 32'(ICMC_en), 32'd1);
      refill(1'b0);

      // Stall during miss with MC ack held.
      fetch(32'h300, 1'b0);
      Sys_rdy = 1'b0; MCIC_en = 1'b1; MCIC_block = mem_block(32'h300);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_icmc_held", 32'(ICMC_en), 32'd1);
         check("stall_no_icif", 32'(ICIF_en), 32'd0);
      end
      Sys_rdy = 1'b1;
      step();
      check("stall_done_icif", 32'(ICIF_en), 32'd1);
      check("stall_done_data", ICIF_data, 32'hC0DE0300);
      step();
      MCIC_en = 1'b0;
      check("stall_single_pulse", 32'(ICIF_en), 32'd0);

      // Asynchronous reset between edges while a miss is outstanding.
      fetch(32'h140, 1'b0);
      #2;
      Sys_rst = 1'b1;
      model_reset();
      #1;
      check("arst_icmc_low", 32'(ICMC_en), 32'd0);
      step();
      Sys_rst = 1'b0;
      fetch(32'h300, 1'b0);
      check("arst_then_miss", 32'(ICMC_en), 32'd1);
      refill(1'b0);
      step();

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the direct-mapped, fixed-2-word ICache.
- Sits between the instruction fetcher (IF) and the memory controller (MC).
- Adds configurable block size, set count and way count, with per-set round-robin replacement.
- Adds a fetch-cancel input (branch flush), a whole-cache invalidate (fence.i), and a clean level req/ack handshake to MC.

Parameters:
- ADDR_WIDTH, 32, address width.
- BLOCK_WIDTH, 2, log2 of 32-bit words per block; BLOCK_SIZE = 1<<BLOCK_WIDTH.
- SET_WIDTH, 6, log2 of set count.
- WAY_WIDTH, 1, log2 of ways; NUM_WAYS = 1<<WAY_WIDTH. Legal values 0..2.

Ports:
- Sys_clk  in  1  clock.
- Sys_rst  in  1  asynchronous, active-high reset.
- Sys_rdy  in  1  global enable; when low, state holds.
- IFIC_en  in  1  fetch request, one-cycle pulse.
- IFIC_addr  in  ADDR_WIDTH  fetch address; bits [1:0]=0.
- ICIF_en  out  1  fetch data valid, one-cycle pulse.
- ICIF_data  out  32  fetched instruction.
- ICMC_en  out  1  refill request, level.
- ICMC_addr  out  ADDR_WIDTH  block-aligned refill address; low BLOCK_WIDTH+2 bits = 0.
- MCIC_en  in  1  refill ack, level; MC holds it until ICMC_en falls.
- MCIC_block  in  32*BLOCK_SIZE  refill data; word k at [32k+31:32k].
- Clear_en  in  1  cancel in-flight/accepted fetch.
- Inv_all  in  1  invalidate all lines.

Behaviour:
- Address split: offset = addr[BLOCK_WIDTH+1:2]; index = next SET_WIDTH bits; tag = remainder.
- Reset (async): all valid bits 0, RR pointers 0, state IDLE, ICIF_en=0, ICIF_data=0, ICMC_en=0, ICMC_addr=0, drop flag 0. Tag/data arrays are not reset.
- Reset mid-miss: ICMC_en falls immediately; MC abandons the transaction.
- Sys_rdy low: ICIF_en driven 0 at each edge; all other registers hold; MCIC_en is not sampled.
- States: IDLE, MISS.
- IDLE, IFIC_en=1, hit in any way: next edge ICIF_en=1 with the selected word (1-cycle latency). At most one way may match.
- IDLE, IFIC_en=1, miss:
  - Go to MISS.
  - Latch offset, index, tag, and victim way.
  - ICMC_en=1; ICMC_addr = block-aligned IFIC_addr.
- Victim selection: lowest-index invalid way; if none invalid, the set's RR pointer, which then increments modulo NUM_WAYS.
- MISS: IFIC_en ignored (IF must not issue). ICMC_en held high until MCIC_en sampled.
- MISS, MCIC_en=1 sampled:
  - Write the whole block into the victim way; set valid and tag.
  - ICMC_en=0; return to IDLE.
  - If drop flag is 0: ICIF_en=1 with the latched-offset word from MCIC_block, same edge as the write.
  - Drop flag cleared.
- Clear_en in IDLE: any IFIC_en in the same cycle is discarded; no response. Clear_en wins.
- Clear_en in MISS: set drop flag. Refill still completes and is written, but ICIF_en stays 0.
- Clear_en in the cycle where ICIF_en would assert: that output is suppressed (ICIF_en=0).
- Inv_all: clear every valid bit at the next edge. RR pointers unchanged.
- Inv_all coinciding with a hit: the hit is still returned.
- Inv_all coinciding with a refill write: the refilled line ends valid; all others invalid.
- Inv_all during MISS with no MCIC_en: invalidates; the refill later lands normally.
- Misbehaving MC:
  - MCIC_en while IDLE: ignored.
  - MCIC_en held high after ICMC_en falls: ignored in IDLE. MC must drop it before the next request.
- Back-to-back: a new IFIC_en is accepted in the cycle after ICIF_en, or the same cycle the refill completes only if the state is already IDLE. Otherwise it is ignored.

Decomposition:
- Package icache_pkg:
  - State enum IDLE/MISS.
  - Derived widths: TAG_WIDTH = ADDR_WIDTH-SET_WIDTH-BLOCK_WIDTH-2; OFFSET_LSB=2.
  - Address-field extraction functions.
- Sub-module icache_way: one way's valid/tag/data arrays with read port (hit, word) and refill write port; instantiated NUM_WAYS times.
- Victim select and RR pointers live in the top level.

Test Plan:
- Parameters BLOCK_WIDTH=1, SET_WIDTH=2, WAY_WIDTH=1 unless noted.
- Cold miss: fetch 0x100 -> ICMC_en=1, ICMC_addr=0x100; MCIC_block={0xB,0xA} -> ICIF_en pulse, data 0xA. Refetch 0x104 -> 1-cycle hit, data 0xB, no ICMC_en.
- Associativity: 0x000, 0x020, 0x040 all map to set 0. After filling 0x000 and 0x020, 0x040 evicts way0 (0x000). Fetch 0x020 hits; 0x000 misses.
- Cancel: miss on 0x200, Clear_en mid-MISS -> refill written, ICIF_en never asserts; refetch 0x200 hits.
- Inv_all after filling 4 lines -> every subsequent fetch misses. Inv_all in the same cycle as MCIC_en -> only that line hits afterward.
- Sys_rdy low during MISS with MCIC_en high for 3 cycles -> no update. Sys_rdy high -> completes once; ICIF_en pulses exactly once.
- Async reset asserted mid-MISS between clock edges -> ICMC_en low before the next edge; all fetches miss after release.
